// File: rtl/wb_burst_mem_slave.sv
// Wishbone B4 registered-feedback slave memory: classic cycles plus linear and
// wrapping bursts served from a byte-enabled synchronous RAM, with range/length errors.
module wb_burst_mem_slave #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH_WORDS = 16384,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_CYCLES = 1,
  parameter int unsigned       MAX_BURST   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADDR_W-1:0]   wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [1:0]          wb_bte_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [4:0]          beat_cnt_o
);

  localparam int unsigned SEL_W     = DATA_W / 8;
  localparam int unsigned OFF_W     = $clog2(SEL_W);
  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [4:0]  BURST_LIM = 5'((MAX_BURST > 31) ? 31 : MAX_BURST);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_ERR} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               oor_q, oor_d;
  logic               we_q;
  logic [1:0]         bte_q;
  logic [3:0]         wait_q;
  logic [4:0]         beat_q;
  logic [DATA_W-1:0]  rd_q;
  logic [DATA_W-1:0]  mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]  adr_off, adr_word;
  logic               adr_ok;
  logic               in_xfer, beat_err, xfer_ack, burst_more;
  logic [IDX_W-1:0]   wrap_mask;

  // Word index relative to the base; an address below the base wraps to a huge
  // index and so lands out of range as well.
  assign adr_off  = wb_adr_i - BASE_ADDR;
  assign adr_word = adr_off >> OFF_W;
  assign adr_ok   = ((adr_word >> IDX_W) == '0);

  assign in_xfer    = (state_q == S_XFER);
  assign burst_more = (wb_cti_i == 3'b010);
  assign beat_err   = oor_q || ((bte_q == 2'b00) && (beat_q >= BURST_LIM));
  assign xfer_ack   = in_xfer && wb_cyc_i && wb_stb_i && !beat_err;

  assign wb_ack_o   = xfer_ack;
  assign wb_err_o   = wb_cyc_i && ((state_q == S_ERR) || (in_xfer && wb_stb_i && beat_err));
  assign wb_rty_o   = 1'b0;
  assign wb_dat_o   = (xfer_ack && !wb_we_i) ? rd_q : '0;
  assign beat_cnt_o = beat_q;

  // Next word index: taken from the bus in IDLE, advanced on each continuing burst beat.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    idx_d     = idx_q;
    oor_d     = oor_q;
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = IDX_W'(3);
      2'b10:   wrap_mask = IDX_W'(7);
      default: wrap_mask = IDX_W'(15);
    endcase
    if (state_q == S_IDLE) begin
      idx_d = adr_word[IDX_W-1:0];
      oor_d = 1'b0;
    end else if (xfer_ack && burst_more) begin
      if (bte_q == 2'b00) begin
        {oor_d, idx_d} = {1'b0, idx_q} + (IDX_W+1)'(1);
      end else begin
        idx_d = (idx_q & ~wrap_mask) | ((idx_q + IDX_W'(1)) & wrap_mask);
      end
    end
  end

  // Reading the next index every cycle keeps rd_q equal to RAM[idx_q] on entry
  // to XFER and across back-to-back burst beats.
  // NOTE: the RAM array has no reset; only the control state is reset.
  always_ff @(posedge clk) begin
    if (xfer_ack && we_q) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (wb_sel_i[b]) mem[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
    rd_q <= mem[idx_d];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      bte_q   <= 2'b00;
      wait_q  <= '0;
      beat_q  <= '0;
    end else begin
      idx_q <= idx_d;
      oor_q <= oor_d;
      if (state_q == S_IDLE) beat_q <= '0;
      if (!wb_cyc_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (wb_stb_i) begin
              we_q    <= wb_we_i;
              bte_q   <= wb_bte_i;
              wait_q  <= WAIT_LOAD;
              state_q <= adr_ok ? S_WAIT : S_ERR;
            end
          end
          S_WAIT: begin
            if (wb_stb_i) begin
              if (wait_q == '0) state_q <= S_XFER;
              else              wait_q  <= wait_q - 4'd1;
            end
          end
          S_XFER: begin
            if (wb_stb_i) begin
              if (beat_err) begin
                state_q <= S_IDLE;
              end else begin
                if (beat_q != 5'd31) beat_q <= beat_q + 5'd1;
                if (!burst_more) state_q <= S_IDLE;
              end
            end
          end
          S_ERR:   state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Randomised bench for wb_burst_mem_slave: a driver pushes expected responses from a
// word-array model into a queue; a monitor pops and compares on every ack/err.
module tb_wb_burst_mem_slave;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int unsigned WAITC = 2;
  localparam int unsigned MAXB  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] dat_o;
  logic        ack, err, rty;
  logic [4:0]  beat;

  wb_burst_mem_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAITC), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .beat_cnt_o(beat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
    logic [4:0]  beat;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every response must match the next queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      check("rty_zero", 32'(rty), 32'd0);
      check("ack_err_excl", 32'(ack & err), 32'd0);
      if (ack || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'({ack, err}), 32'd0);
        end else begin
          x = exp_q.pop_front();
          check("resp_is_err", 32'(err), 32'(x.is_err));
          check("rd_data", dat_o, x.data);
          check("beat_cnt", 32'(beat), 32'(x.beat));
        end
      end else begin
        check("dat_idle_zero", dat_o, 32'd0);
      end
    end
  end

  // One bus cycle. Expected responses come from the word-array model: linear beats
  // walk idx0+k, wrap beats stay inside the aligned N-word block.
  task automatic run_cycle(input bit w, input logic [31:0] a, input bit burst,
                           input logic [1:0] bt, input int nbeats,
                           input int gap_at, input int gap_len,
                           input bit rnd, input logic [31:0] wdata0, input logic [3:0] s);
    int unsigned idx0, idx, wlen;
    int          acked, n, exp_lat;
    bit          done, e;
    exp_t        x;
    logic [31:0] d;
    idx0  = (a - BASE) >> 2;
    acked = 0;
    done  = 1'b0;
    wlen  = 0;
    if (burst) begin
      case (bt)
        2'b01:   wlen = 4;
        2'b10:   wlen = 8;
        2'b11:   wlen = 16;
        default: wlen = 0;
      endcase
    end
    cyc = 1'b1;
    for (int k = 0; k < nbeats && !done; k++) begin
      if (idx0 >= DEPTH) begin
        idx = idx0;
        e   = 1'b1;
      end else if (wlen != 0) begin
        idx = (idx0 & ~(wlen - 1)) + ((idx0 + 32'(k)) % wlen);
        e   = 1'b0;
      end else begin
        idx = idx0 + 32'(k);
        e   = (idx >= DEPTH) || (32'(k) >= MAXB);
      end
      d     = rnd ? $urandom : wdata0 + 32'(k);
      stb   = 1'b1;
      we    = w;
      adr   = a;
      sel   = s;
      dat_i = d;
      bte   = bt;
      cti   = !burst ? 3'b000 : (k == nbeats - 1) ? 3'b111 : 3'b010;
      x.is_err = e;
      x.beat   = 5'(acked);
      x.data   = '0;
      if (!e) begin
        if (w) begin
          for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          x.data = ref_mem[idx];
        end
      end
      exp_q.push_back(x);
      n = 0;
      while (1) begin
        @(negedge clk);
        if (ack || err || n >= 64) break;
        n++;
      end
      exp_lat = (k != 0) ? 0 : (idx0 >= DEPTH) ? 1 : int'(WAITC) + 1;
      check("resp_latency", 32'(n), 32'(exp_lat));
      if (!(ack || err)) begin
        exp_q.delete();
        done = 1'b1;
      end
      @(posedge clk); #1;
      if (e) done = 1'b1;
      else if (!done) acked++;
      if (!done && k == gap_at && k < nbeats - 1 && gap_len > 0) begin
        stb = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    cyc = 1'b0;
    stb = 1'b0;
    cti = 3'b000;
    check("beat_cnt_end", 32'(beat), 32'(acked));
    @(posedge clk); #1;
    check("beat_cnt_clr", 32'(beat), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, nb;
    int unsigned idx;
    logic [31:0] a;
    logic [3:0]  s;
    bit          w;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rty", 32'(rty), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_beat", 32'(beat), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole RAM so every later read has a known model value.
    for (int wd = 0; wd < int'(DEPTH); wd += 16)
      run_cycle(1, BASE + 32'(wd * 4), 1, 2'b00, 16, -1, 0, 1, 32'd0, 4'hF);

    // Classic write then read.
    run_cycle(1, BASE + 32'h100, 0, 2'b00, 1, -1, 0, 0, 32'hDEAD_BEEF, 4'hF);
    run_cycle(0, BASE + 32'h100, 0, 2'b00, 1, -1, 0, 0, 32'd0, 4'hF);
    // Byte-enable merge: expect 0xFF22FF44.
    run_cycle(1, BASE + 32'h40, 0, 2'b00, 1, -1, 0, 0, 32'hFFFF_FFFF, 4'hF);
    run_cycle(1, BASE + 32'h40, 0, 2'b00, 1, -1, 0, 0, 32'h1122_3344, 4'b0101);
    run_cycle(0, BASE + 32'h40, 0, 2'b00, 1, -1, 0, 0, 32'd0, 4'hF);
    // Preload 0..7 then 8-beat linear read.
    run_cycle(1, BASE + 32'h80, 1, 2'b00, 8, -1, 0, 0, 32'd0, 4'hF);
    run_cycle(0, BASE + 32'h80, 1, 2'b00, 8, -1, 0, 0, 32'd0, 4'hF);
    // Wrap4 from 0x88 with a 2-cycle strobe gap after the second beat.
    run_cycle(0, BASE + 32'h88, 1, 2'b01, 4, 1, 2, 0, 32'd0, 4'hF);
    // Out of range, linear run off the end, and over-long linear burst.
    run_cycle(0, BASE + 32'(DEPTH * 4), 0, 2'b00, 1, -1, 0, 0, 32'd0, 4'hF);
    run_cycle(0, BASE - 32'd4, 0, 2'b00, 1, -1, 0, 0, 32'd0, 4'hF);
    run_cycle(0, BASE + 32'((DEPTH - 1) * 4), 1, 2'b00, 2, -1, 0, 0, 32'd0, 4'hF);
    run_cycle(0, BASE + 32'h200, 1, 2'b00, 20, -1, 0, 0, 32'd0, 4'hF);

    // Reset while the slave is still in its wait states; strobe stays up through reset.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h80; cti = 3'b010; bte = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_dat", dat_o, 32'd0);
    check("midrst_beat", 32'(beat), 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    run_cycle(0, BASE + 32'h100, 0, 2'b00, 1, -1, 0, 0, 32'd0, 4'hF);

    // Random mix of classic, linear, wrap, near-top and out-of-range cycles.
    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 4);
      idx  = $urandom_range(0, DEPTH - 1);
      a    = BASE + idx * 4 + 32'($urandom_range(0, 3));
      w    = 1'($urandom_range(0, 1));
      s    = 4'($urandom_range(1, 15));
      nb   = $urandom_range(1, 20);
      case (kind)
        0: run_cycle(w, a, 0, 2'b00, 1, -1, 0, 1, 32'd0, s);
        1: run_cycle(w, a, 1, 2'b00, nb, $urandom_range(0, 5), $urandom_range(0, 3), 1, 32'd0, s);
        2: run_cycle(w, a, 1, 2'($urandom_range(1, 3)), nb, $urandom_range(0, 5),
                     $urandom_range(0, 3), 1, 32'd0, s);
        3: run_cycle(w, BASE + 32'((DEPTH - $urandom_range(1, 4)) * 4), 1, 2'b00,
                     $urandom_range(1, 8), -1, 0, 1, 32'd0, s);
        default: begin
          if ($urandom_range(0, 1) == 1) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
          else                           a = BASE - 32'($urandom_range(1, 16) * 4);
          run_cycle(w, a, 1'($urandom_range(0, 1)), 2'b00, 2, -1, 0, 1, 32'd0, s);
        end
      endcase
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
